// File: rtl/doc_port_arbiter_pkg.sv
// Shared definitions for the Document port arbiter slice.
//   - Default widths and the blank code for the Document text RAM.
//   - state_e: arbiter FSM states (IDLE serves requesters, CLEAR sweeps).
//   - req_e:   requester identity, used as the round-robin last-grant value.
package doc_arb_pkg;

    localparam int          ADDR_W_DEF     = 9;
    localparam int          DATA_W_DEF     = 8;
    localparam int          DEPTH_DEF      = 512;
    localparam logic [7:0]  BLANK_CODE_DEF = 8'h20;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_e;

    typedef enum logic {
        REQ_ED = 1'b0,
        REQ_RD = 1'b1
    } req_e;

endpackage

// File: rtl/doc_port_arbiter_if.sv
// Bundle of every non-clock/reset signal of doc_port_arbiter.
//   slave  : seen from the arbiter (requests and mem_spo in; grants, bus, status out)
//   master : seen from the surrounding logic / bench (mirror of slave)
//   dbg_state exposes the arbiter FSM state for observation.
// Handshake: a requester raises req with stable addr/data and holds them until
// it sees gnt high at a rising edge; that edge performs the transaction and
// the requester may drop or change req right after it.
interface doc_port_arbiter_if
    import doc_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic              clr_start;
    logic              clr_busy;
    logic              clr_done;
    logic              ed_req;
    logic [ADDR_W-1:0] ed_addr;
    logic [DATA_W-1:0] ed_data;
    logic              ed_gnt;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_gnt;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic [ADDR_W-1:0] mem_a;
    logic [DATA_W-1:0] mem_d;
    logic              mem_we;
    logic [DATA_W-1:0] mem_spo;
    state_e            dbg_state;

    modport slave (
        input  clr_start, ed_req, ed_addr, ed_data, rd_req, rd_addr, mem_spo,
        output clr_busy, clr_done, ed_gnt, rd_gnt, rd_data, rd_valid,
               mem_a, mem_d, mem_we, dbg_state
    );

    modport master (
        output clr_start, ed_req, ed_addr, ed_data, rd_req, rd_addr, mem_spo,
        input  clr_busy, clr_done, ed_gnt, rd_gnt, rd_data, rd_valid,
               mem_a, mem_d, mem_we, dbg_state
    );
endinterface

// File: rtl/doc_port_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter (editor vs reader).
// Ports:
//   clk, rst       clock, synchronous active-low reset
//   en             arbitration allowed this cycle (low while clearing / in reset)
//   req_ed, req_rd requests
//   gnt_ed, gnt_rd one-hot grants, combinational
// On a tie the requester that did not win last time is granted; the last-grant
// register resets to REQ_RD so the editor wins the first tie.
module rr_arb2
    import doc_arb_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic req_ed,
    input  logic req_rd,
    output logic gnt_ed,
    output logic gnt_rd
);
    req_e last_q;
    req_e last_d;

    always_comb begin
        gnt_ed = en && req_ed && (!req_rd || (last_q == REQ_RD));
        gnt_rd = en && req_rd && (!req_ed || (last_q == REQ_ED));
        last_d = last_q;
        if (gnt_ed) begin
            last_d = REQ_ED;
        end else if (gnt_rd) begin
            last_d = REQ_RD;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            last_q <= REQ_RD;
        end else begin
            last_q <= last_d;
        end
    end
endmodule

// File: rtl/doc_port_arbiter.sv
// doc_port_arbiter: owns the single port of the Document text RAM and shares it
// between the editor (writes), the UART reader (reads) and a clear sequencer.
// Ports:
//   clk   system clock
//   rst   synchronous, active-low reset
//   bus   doc_port_arbiter_if.slave: clr_start/busy/done, editor and reader
//         handshakes, Document port (mem_a/mem_d/mem_we/mem_spo), dbg_state
// Optional macro DOC_ARB_CLEAR_ON_RESET_EN: reset enters CLEAR so the Document
// is blanked at power-up; undefined, reset enters IDLE and RAM is untouched.
module doc_port_arbiter
    import doc_arb_pkg::*;
#(
    parameter int               ADDR_W     = ADDR_W_DEF,
    parameter int               DATA_W     = DATA_W_DEF,
    parameter int               DEPTH      = DEPTH_DEF,
    parameter logic [DATA_W-1:0] BLANK_CODE = BLANK_CODE_DEF
)(
    input  logic clk,
    input  logic rst,
    doc_port_arbiter_if.slave bus
);
    localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_W  = (ADDR_W + 1)'(DEPTH);

`ifdef DOC_ARB_CLEAR_ON_RESET_EN
    localparam state_e RESET_STATE = CLEAR;
`else
    localparam state_e RESET_STATE = IDLE;
`endif

    state_e            state_q,    state_d;
    logic [ADDR_W-1:0] clr_cnt_q,  clr_cnt_d;
    logic              clr_done_q, clr_done_d;
    logic [DATA_W-1:0] rd_data_q,  rd_data_d;
    logic              rd_valid_q, rd_valid_d;

    logic              arb_en;
    logic              gnt_ed;
    logic              gnt_rd;
    logic [ADDR_W-1:0] mem_a;
    logic [DATA_W-1:0] mem_d;
    logic              mem_we;

    // Grants are held off during reset so nothing touches the RAM in that cycle.
    assign arb_en = rst && (state_q == IDLE);

    rr_arb2 u_rr_arb2 (
        .clk    (clk),
        .rst    (rst),
        .en     (arb_en),
        .req_ed (bus.ed_req),
        .req_rd (bus.rd_req),
        .gnt_ed (gnt_ed),
        .gnt_rd (gnt_rd)
    );

    always_comb begin
        state_d    = state_q;
        clr_cnt_d  = clr_cnt_q;
        clr_done_d = 1'b0;
        rd_data_d  = rd_data_q;
        rd_valid_d = gnt_rd;
        mem_a      = '0;
        mem_d      = '0;
        mem_we     = 1'b0;
        case (state_q)
            IDLE: begin
                if (gnt_ed) begin
                    mem_a  = bus.ed_addr;
                    mem_d  = bus.ed_data;
                    // Out-of-range editor writes are granted but dropped.
                    mem_we = ({1'b0, bus.ed_addr} < DEPTH_W);
                end else if (gnt_rd) begin
                    mem_a     = bus.rd_addr;
                    rd_data_d = bus.mem_spo;
                end
                // The grant above is still served; the sweep starts next cycle.
                if (bus.clr_start) begin
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                mem_a  = clr_cnt_q;
                mem_d  = BLANK_CODE;
                mem_we = 1'b1;
                if (clr_cnt_q == CLR_LAST) begin
                    clr_cnt_d  = '0;
                    clr_done_d = 1'b1;
                    state_d    = IDLE;
                end else begin
                    clr_cnt_d = clr_cnt_q + ADDR_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (!rst) begin
            mem_a  = '0;
            mem_d  = '0;
            mem_we = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= RESET_STATE;
            clr_cnt_q  <= '0;
            clr_done_q <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            clr_done_q <= clr_done_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign bus.mem_a     = mem_a;
    assign bus.mem_d     = mem_d;
    assign bus.mem_we    = mem_we;
    assign bus.ed_gnt    = gnt_ed;
    assign bus.rd_gnt    = gnt_rd;
    assign bus.rd_data   = rd_data_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.clr_busy  = rst && (state_q == CLEAR);
    assign bus.clr_done  = clr_done_q;
    assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_doc_port_arbiter.sv
// Bench for doc_port_arbiter: emulated Document RAM, cycle-level reference
// model of the arbitration/clear rules, directed phases and a random phase.
module tb_doc_port_arbiter;
    import doc_arb_pkg::*;

    localparam int         AW    = 9;
    localparam int         DW    = 8;
    localparam int         DEPTH = 512;
    localparam logic [7:0] BLANK = 8'h20;

    logic clk = 1'b0;
    logic rst = 1'b0;

    doc_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    doc_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .BLANK_CODE(BLANK)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- emulated Document RAM ----------------
    logic [DW-1:0] ram [DEPTH];
    assign bus.mem_spo = ram[bus.mem_a];
    always @(posedge clk) begin
        if (bus.mem_we) ram[bus.mem_a] <= bus.mem_d;
    end

    // ---------------- reference model state ----------------
    logic [DW-1:0] model_ram [DEPTH];
    logic [DW-1:0] snap_ram  [DEPTH];
    int            m_left;        // blank writes still to do (0 = not clearing)
    bit            m_last_rd;     // last winner was the reader
    bit            m_valid;
    bit            m_done;
    logic [DW-1:0] m_rd_data;
    bit            g_ed, g_rd;    // model grants of the last cycle

    int n_checks = 0;
    int n_fail   = 0;
    int obs_busy_cnt, obs_done_cnt, obs_ed_cnt, obs_rd_cnt;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
`ifdef DOC_ARB_CLEAR_ON_RESET_EN
        m_left = DEPTH;
`else
        m_left = 0;
`endif
        m_last_rd = 1'b1;
        m_valid   = 1'b0;
        m_done    = 1'b0;
        m_rd_data = '0;
    endtask

    // One clock cycle: check at negedge, advance model at posedge, settle #1.
    task automatic cycle();
        bit            e_ed, e_rd, e_we;
        logic [AW-1:0] e_a;
        logic [DW-1:0] e_d;
        @(negedge clk);
        e_ed = 0; e_rd = 0; e_we = 0; e_a = '0; e_d = '0;
        if (rst && m_left > 0) begin
            e_we = 1; e_a = AW'(DEPTH - m_left); e_d = BLANK;
        end else if (rst) begin
            if (bus.ed_req && bus.rd_req) begin
                e_ed = m_last_rd;
                e_rd = !m_last_rd;
            end else begin
                e_ed = bus.ed_req;
                e_rd = bus.rd_req;
            end
            if (e_ed) begin
                e_a = bus.ed_addr; e_d = bus.ed_data; e_we = (int'(bus.ed_addr) < DEPTH);
            end
            if (e_rd) e_a = bus.rd_addr;
        end
        check_eq("ed_gnt",   bus.ed_gnt,   e_ed);
        check_eq("rd_gnt",   bus.rd_gnt,   e_rd);
        check_eq("mem_we",   bus.mem_we,   e_we);
        check_eq("mem_a",    bus.mem_a,    e_a);
        check_eq("mem_d",    bus.mem_d,    e_d);
        check_eq("clr_busy", bus.clr_busy, rst && (m_left > 0));
        check_eq("clr_done", bus.clr_done, m_done);
        check_eq("rd_valid", bus.rd_valid, m_valid);
        check_eq("rd_data",  bus.rd_data,  m_rd_data);
        check_eq("state",    bus.dbg_state == CLEAR, m_left > 0);
        obs_busy_cnt += int'(bus.clr_busy);
        obs_done_cnt += int'(bus.clr_done);
        obs_ed_cnt   += int'(bus.ed_gnt);
        obs_rd_cnt   += int'(bus.rd_gnt);
        @(posedge clk);
        if (!rst) begin
            model_reset();
        end else begin
            if (e_rd) m_rd_data = model_ram[bus.rd_addr];
            m_valid = e_rd;
            if (e_we) model_ram[e_a] = e_d;
            if (e_ed) m_last_rd = 1'b0;
            if (e_rd) m_last_rd = 1'b1;
            m_done = 1'b0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) m_done = 1'b1;
            end else if (bus.clr_start) begin
                m_left = DEPTH;
            end
        end
        g_ed = e_ed;
        g_rd = e_rd;
        #1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_ed(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.ed_req = 1'b1; bus.ed_addr = a; bus.ed_data = d;
    endtask

    task automatic drive_rd(input logic [AW-1:0] a);
        bus.rd_req = 1'b1; bus.rd_addr = a;
    endtask

    // Drop granted requests, then raise new ones at random.
    task automatic rand_drive(input int p_ed, input int p_rd);
        if (g_ed) bus.ed_req = 1'b0;
        if (g_rd) bus.rd_req = 1'b0;
        if (!bus.ed_req && $urandom_range(0, 99) < p_ed)
            drive_ed(AW'($urandom_range(0, DEPTH - 1)), DW'($urandom_range(0, 255)));
        if (!bus.rd_req && $urandom_range(0, 99) < p_rd)
            drive_rd(AW'($urandom_range(0, DEPTH - 1)));
    endtask

    task automatic wait_idle();
        int budget;
        budget = 0;
        while (m_left > 0 && budget < 2 * DEPTH) begin
            cycle();
            budget++;
        end
        check_eq("wait_idle_bound", m_left, 0);
    endtask

    task automatic reset_counts();
        obs_busy_cnt = 0; obs_done_cnt = 0; obs_ed_cnt = 0; obs_rd_cnt = 0;
    endtask

    task automatic compare_ram(input string tag);
        int bad;
        bad = 0;
        for (int i = 0; i < DEPTH; i++) if (ram[i] !== model_ram[i]) bad++;
        check_eq(tag, bad, 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int bad;
        logic [DW-1:0] v;
        bus.clr_start = 0; bus.ed_req = 0; bus.ed_addr = '0; bus.ed_data = '0;
        bus.rd_req = 0; bus.rd_addr = '0;
        g_ed = 0; g_rd = 0;
        reset_counts();
        for (int i = 0; i < DEPTH; i++) begin
            v = DW'($urandom_range(0, 255));
            ram[i]       <= v;
            model_ram[i]  = v;
        end

        // reset
        rst = 1'b0;
        @(posedge clk);
        model_reset();
        #1;
        repeat (2) cycle();
        rst = 1'b1;
        reset_counts();
        cycle();
`ifdef DOC_ARB_CLEAR_ON_RESET_EN
        check_eq("por_busy_first", obs_busy_cnt, 1);
        wait_idle();
        repeat (2) cycle();
        check_eq("por_busy_len", obs_busy_cnt, DEPTH);
        check_eq("por_done_cnt", obs_done_cnt, 1);
`else
        repeat (3) cycle();
        check_eq("no_por_busy", obs_busy_cnt, 0);
`endif

        // single editor write
        drive_ed(9'h023, 8'h41);
        cycle();
        bus.ed_req = 0;
        cycle();
        check_eq("ram_023", ram[9'h023], 8'h41);

        // both requesters held: alternate ED, RD, ED, RD
        reset_counts();
        drive_ed(9'h030, 8'h11);
        drive_rd(9'h023);
        for (int k = 0; k < 4; k++) begin
            cycle();
            if (g_ed) drive_ed(AW'(9'h031 + k), DW'(8'h12 + k));
            if (g_rd) drive_rd(AW'(9'h030 + k));
        end
        bus.ed_req = 0; bus.rd_req = 0;
        cycle();
        check_eq("alt_ed_cnt", obs_ed_cnt, 2);
        check_eq("alt_rd_cnt", obs_rd_cnt, 2);

        // full clear with an editor write raised mid-sweep
        bus.clr_start = 1;
        cycle();
        bus.clr_start = 0;
        reset_counts();
        for (int k = 0; k < DEPTH + 8; k++) begin
            if (k == 10) drive_ed(9'h005, 8'h5A);
            if (k == 20) bus.clr_start = 1;
            if (k == 21) bus.clr_start = 0;
            cycle();
            if (g_ed) bus.ed_req = 0;
        end
        check_eq("clr_busy_len", obs_busy_cnt, DEPTH);
        check_eq("clr_done_cnt", obs_done_cnt, 1);
        check_eq("clr_ed_after", obs_ed_cnt, 1);
        check_eq("ram_005", ram[5], 8'h5A);
        bad = 0;
        for (int i = 0; i < DEPTH; i++) if (i != 5 && ram[i] !== BLANK) bad++;
        check_eq("clr_blank_cnt", bad, 0);

        // fresh pattern, then reset at sweep cycle 100
        for (int k = 0; k < 64; k++) begin
            rand_drive(90, 0);
            cycle();
        end
        bus.ed_req = 0;
        cycle();
        for (int i = 0; i < DEPTH; i++) snap_ram[i] = ram[i];
        bus.clr_start = 1;
        cycle();
        bus.clr_start = 0;
        for (int k = 0; k < 100; k++) cycle();
        rst = 1'b0;
        cycle();
        rst = 1'b1;
        reset_counts();
        repeat (4) cycle();
`ifndef DOC_ARB_CLEAR_ON_RESET_EN
        check_eq("abort_busy", obs_busy_cnt, 0);
        check_eq("abort_done", obs_done_cnt, 0);
        bad = 0;
        for (int i = 100; i < DEPTH; i++) if (ram[i] !== snap_ram[i]) bad++;
        check_eq("abort_kept", bad, 0);
        bad = 0;
        for (int i = 0; i < 100; i++) if (ram[i] !== BLANK) bad++;
        check_eq("abort_blanked", bad, 0);
`endif
        wait_idle();

        // random phase
        for (int k = 0; k < 3000; k++) begin
            rand_drive(40, 40);
            bus.clr_start = ($urandom_range(0, 199) == 0);
            rst = ($urandom_range(0, 499) != 0);
            cycle();
        end
        rst = 1'b1; bus.clr_start = 0; bus.ed_req = 0; bus.rd_req = 0;
        cycle();
        wait_idle();
        cycle();
        compare_ram("ram_final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/doc_port_arbiter.md
Name: doc_port_arbiter

Overview:
- Owns the single read/write port of the Document text RAM: distributed RAM with async read on `spo` and sync write.
- Shares that port between three requesters:
  - the text editor (character writes);
  - the UART messenger (sequential reads);
  - an internal clear sequencer that blanks every cell.
- Replaces ad-hoc port muxing: one transaction per cycle, explicit grants, and a clear sweep that is guaranteed not to collide with live traffic.

Parameters:
- ADDR_W, 9: Document address width, `{row[3:0], col[4:0]}`.
- DATA_W, 8: character code width.
- DEPTH, 512: number of cells swept by a clear; must be ≤ 2^ADDR_W.
- BLANK_CODE, 8'h20: code written to every cell on clear.

Ports:
- clk  in  1  system clock (100 MHz domain).
- rst  in  1  synchronous, active-low reset.
- clr_start  in  1  one-cycle pulse; request a full clear.
- clr_busy  out  1  high while the sweep is in progress.
- clr_done  out  1  one-cycle pulse after the last blank write.
- ed_req  in  1  editor write request; held until granted.
- ed_addr  in  ADDR_W  editor write address.
- ed_data  in  DATA_W  editor write data.
- ed_gnt  out  1  write performed at this clock edge.
- rd_req  in  1  reader request; held until granted.
- rd_addr  in  ADDR_W  reader address.
- rd_gnt  out  1  read address presented this cycle.
- rd_data  out  DATA_W  registered read data.
- rd_valid  out  1  one-cycle pulse; rd_data valid.
- mem_a  out  ADDR_W  Document port address.
- mem_d  out  DATA_W  Document write data.
- mem_we  out  1  Document write enable.
- mem_spo  in  DATA_W  Document async read data.

Behaviour:
- Reset (rst==0 at posedge):
  - state ← IDLE, clr_cnt ← 0, rr_last ← RD (editor wins the first tie).
  - rd_data ← 0; clr_busy, clr_done, rd_valid ← 0.
  - ed_gnt, rd_gnt, mem_we ← 0; mem_a, mem_d ← 0.
- Transactions: one per cycle.
  - ed_gnt, rd_gnt, mem_a, mem_d and mem_we are combinational from current state and requests.
  - A requester may drop or change its req after the edge at which its gnt was high.
- IDLE arbitration:
  - Only one of ed_req/rd_req asserted → it wins.
  - Both asserted → round-robin: the winner is the one not equal to rr_last; rr_last updates to the winner on each grant.
  - Worst-case wait for either requester: 1 cycle while IDLE.
- Editor grant: mem_a=ed_addr, mem_d=ed_data, mem_we=1, ed_gnt=1. If ed_addr ≥ DEPTH: mem_we=0, but ed_gnt is still asserted (write dropped).
- Reader grant:
  - mem_a=rd_addr, mem_we=0, rd_gnt=1.
  - At that edge rd_data ← mem_spo; rd_valid=1 for the next cycle only. Latency grant→valid = 1 cycle.
  - Back-to-back reads give rd_valid high on consecutive cycles.
- No grant: mem_we=0, mem_a=0, mem_d=0.
- FSM:
  - IDLE → CLEAR on clr_start. Requests present in the clr_start cycle are still arbitrated and served; the sweep begins next cycle.
  - CLEAR: mem_a=clr_cnt, mem_d=BLANK_CODE, mem_we=1, clr_busy=1, ed_gnt=rd_gnt=0; clr_cnt increments each cycle.
  - At clr_cnt==DEPTH-1: write the last cell, clr_cnt ← 0, state → IDLE, clr_done=1 in the following cycle (same cycle clr_busy falls).
  - Sweep length is exactly DEPTH cycles.
- Boundary cases:
  - clr_start during CLEAR: ignored; no restart, no extension.
  - Requests held through CLEAR are served afterwards in round-robin order, so an editor write issued mid-clear lands after the sweep and survives.
  - Reset mid-sweep: sweep aborts immediately, state IDLE; cells not yet reached keep their old contents.
  - Reset while rd_valid would pulse: the pulse is suppressed.

Optional Feature:
- Macro: DOC_ARB_CLEAR_ON_RESET_EN.
- Defined: reset leaves state=CLEAR, clr_cnt=0, clr_busy=1 in the first cycle after reset, giving a guaranteed blank Document at power-up; clr_done pulses after DEPTH cycles.
- Undefined: reset leaves IDLE and RAM contents are untouched.

Decomposition:
- Package doc_arb_pkg holds:
  - ADDR_W, DATA_W, BLANK_CODE defaults;
  - state enum {IDLE, CLEAR};
  - requester enum {REQ_ED, REQ_RD} for rr_last.
- One sub-module, rr_arb2: two-way round-robin with a last-grant register, with an enable input (low during CLEAR) and grant outputs.
- The FSM, clear counter and read-data register stay in doc_port_arbiter.

Test Plan:
- Reset, then ed_req with ed_addr=9'h023, ed_data=8'h41 → same cycle mem_we=1, mem_a=9'h023, mem_d=8'h41, ed_gnt=1; the RAM model holds 8'h41 at 9'h023.
- ed_req and rd_req held together for 4 cycles → grants alternate ED, RD, ED, RD; rd_valid follows each rd_gnt by exactly 1 cycle with model data.
- clr_start pulse with DEPTH=512 → clr_busy high for exactly 512 cycles; every address 0..511 written with 8'h20 in order; clr_done pulses once after the last write.
- ed_req (addr 9'h005, data 8'h5A) raised at sweep cycle 10 → no ed_gnt until clr_busy falls, then granted; the final RAM[5]=8'h5A.
- Reset asserted at sweep cycle 100 → next cycle state IDLE, clr_busy=0, no clr_done; RAM[100..511] keep their pre-clear values.
- Build with DOC_ARB_CLEAR_ON_RESET_EN → after rst release, clr_busy=1 immediately and clr_done arrives after 512 cycles; without the macro, clr_busy stays 0.
